// File: rtl/spi_master_ctrl_pkg.sv
// spi_master_ctrl_pkg: shared widths, command codes and FSM state encodings for the SPI host controller
package spi_master_ctrl_pkg;
  localparam int ADDR_SIZE = 8;
  localparam int FRAME_W = ADDR_SIZE + 2;
  typedef enum logic [1:0] {WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11} cmd_e;
  typedef enum logic [2:0] {M_IDLE, M_START, M_SHIFT, M_TURN, M_RECV, M_STOP} MSTATE_e;
endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: host command/response handshake between a host and the SPI master controller
interface spi_master_ctrl_if import spi_master_ctrl_pkg::*;;
  logic req_valid, req_ready, rsp_valid, err, busy;
  logic [1:0] req_cmd;
  logic [ADDR_SIZE-1:0] req_data, rsp_data;
  modport master(output req_valid, req_cmd, req_data, input req_ready, rsp_valid, rsp_data, err, busy);
  modport slave(input req_valid, req_cmd, req_data, output req_ready, rsp_valid, rsp_data, err, busy);
endinterface

// File: rtl/spi_master_ctrl_shifter.sv
// spi_master_shifter: parallel-load TX frame shifter and serial-in RX byte shifter
module spi_master_shifter import spi_master_ctrl_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 capture,
  input  logic                 miso,
  input  logic [FRAME_W-1:0]   frame,
  output logic                 tx_msb,
  output logic [ADDR_SIZE-1:0] rx_word
);
  logic [FRAME_W-1:0] tx;
  logic [ADDR_SIZE-1:0] rx;
  always_ff @(posedge clk)
    if (!rst_n) begin
      tx <= '0;
      rx <= '0;
    end else begin
      tx <= load ? frame : shift ? {tx[FRAME_W-2:0], 1'b0} : tx;
      rx <= capture ? rx_word : rx;
    end
  assign tx_msb = tx[FRAME_W-1];
  // includes the bit sampled this cycle so the response can be registered on the last RECV edge
  assign rx_word = {rx[ADDR_SIZE-2:0], miso};
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: sequences framed SPI transactions, captures read data and rejects reads without an address
module spi_master_ctrl import spi_master_ctrl_pkg::*; #(
  parameter int RD_LAT = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_ctrl_if.slave bus,
  output logic             SS_n,
  output logic             MOSI,
  input  logic             MISO
);
  localparam logic [2:0] IDLE = M_IDLE;
  localparam logic [2:0] START = M_START;
  localparam logic [2:0] SHIFT = M_SHIFT;
  localparam logic [2:0] TURN = M_TURN;
  localparam logic [2:0] RECV = M_RECV;
  localparam logic [2:0] STOP = M_STOP;
  logic [2:0] state, nxt;
  logic [3:0] bit_cnt;
  logic [1:0] cmd_q;
  logic rd_addr_valid, hs, reject, tx_msb;
  logic [ADDR_SIZE-1:0] rx_word;
  assign hs = bus.req_valid && state == IDLE;
  assign reject = bus.req_cmd == RD_DATA && !rd_addr_valid;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = hs && !reject ? START : IDLE;
      START:   nxt = SHIFT;
      SHIFT:   nxt = bit_cnt == 4'(FRAME_W-1) ? (cmd_q == RD_DATA ? TURN : STOP) : SHIFT;
      TURN:    nxt = bit_cnt == 4'(RD_LAT-1) ? RECV : TURN;
      RECV:    nxt = bit_cnt == 4'(ADDR_SIZE-1) ? STOP : RECV;
      STOP:    nxt = bit_cnt == 4'(GAP_CYCLES-1) ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      cmd_q <= '0;
      rd_addr_valid <= 1'b0;
      SS_n <= 1'b1;
      MOSI <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data <= '0;
      bus.err <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= nxt;
      bit_cnt <= (nxt != state || state == IDLE) ? '0 : bit_cnt + 4'd1;
      if (hs) cmd_q <= bus.req_cmd;
      if (nxt == STOP && state != STOP)
        rd_addr_valid <= cmd_q == RD_ADDR ? 1'b1 : cmd_q == RD_DATA ? 1'b0 : rd_addr_valid;
      SS_n <= nxt == IDLE || nxt == STOP;
      MOSI <= nxt == SHIFT && tx_msb;
      bus.req_ready <= nxt == IDLE;
      bus.rsp_valid <= state == RECV && nxt == STOP;
      if (state == RECV && nxt == STOP) bus.rsp_data <= rx_word;
      bus.err <= hs && reject;
      bus.busy <= nxt != IDLE;
    end
  spi_master_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hs && !reject),
    .shift   (nxt == SHIFT),
    .capture (state == RECV),
    .miso    (MISO),
    .frame   ({bus.req_cmd, bus.req_data}),
    .tx_msb  (tx_msb),
    .rx_word (rx_word)
  );
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: per-cycle waveform model of the SPI master plus directed and random stimulus
module tb_spi_master_ctrl;
  localparam int RD_LAT = 2;
  localparam int GAP = 1;
  typedef struct packed {
    logic ss, mosi, busy, ready, rv, err, miso;
    logic [7:0] rd;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n, MOSI;
  logic MISO = 1'b0;
  int checks = 0, failures = 0;
  spi_master_ctrl_if bus();
  spi_master_ctrl #(.RD_LAT(RD_LAT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event t=%0t", name, $time);
  endtask

  // Model: the expected outputs of each cycle, expanded from the frame rules at acceptance time
  ent_t q[$];
  ent_t cur;
  logic [7:0] mem [256];
  logic [7:0] wa = 8'h00, ra = 8'h00, exp_rd = 8'h00;
  bit rav = 0, prev_ready = 0, started = 0;

  function automatic ent_t mk(input logic ss, mosi, busy, ready, miso);
    ent_t e;
    e = '0;
    e.ss = ss; e.mosi = mosi; e.busy = busy; e.ready = ready; e.miso = miso;
    return e;
  endfunction

  task automatic build(input logic [1:0] c, input logic [7:0] d);
    logic [9:0] f;
    logic [7:0] b;
    ent_t e;
    f = {c, d};
    b = 8'h00;
    case (c)
      2'd0: wa = d;
      2'd1: mem[wa] = d;
      2'd2: begin ra = d; rav = 1; end
      default: begin b = mem[ra]; rav = 0; end
    endcase
    q.push_back(mk(0, 0, 1, 0, 1'($urandom)));
    for (int i = 0; i < 10; i++) q.push_back(mk(0, f[9-i], 1, 0, 1'($urandom)));
    if (c == 2'd3) begin
      for (int i = 0; i < RD_LAT; i++) q.push_back(mk(0, 0, 1, 0, 1'($urandom)));
      for (int k = 0; k < 8; k++) q.push_back(mk(0, 0, 1, 0, b[7-k]));
    end
    for (int g = 0; g < GAP; g++) begin
      e = mk(1, 0, 1, 0, 1'($urandom));
      if (g == 0 && c == 2'd3) begin e.rv = 1; e.rd = b; end
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    started = 1;
    if (!rst_n) begin
      q.delete();
      rav = 0;
      exp_rd = 8'h00;
      cur = mk(1, 0, 0, 1, 0);
    end else begin
      if (q.size() == 0) begin
        cur = mk(1, 0, 0, 1, 0);
        if (bus.req_valid && prev_ready) begin
          if (bus.req_cmd == 2'd3 && !rav) cur.err = 1;
          else begin
            build(bus.req_cmd, bus.req_data);
            cur = q.pop_front();
          end
        end
      end else cur = q.pop_front();
      if (cur.rv) exp_rd = cur.rd;
    end
    prev_ready = cur.ready;
  end

  always @(negedge clk) if (started) begin
    chk("ss_n", SS_n, cur.ss);
    chk("mosi", MOSI, cur.mosi);
    chk("busy", bus.busy, cur.busy);
    chk("req_ready", bus.req_ready, cur.ready);
    chk("rsp_valid", bus.rsp_valid, cur.rv);
    chk("err", bus.err, cur.err);
    chk("rsp_data", bus.rsp_data, exp_rd);
    MISO = cur.miso;
  end

  // Observation counters used by the hand-computed expectations
  int cyc = 0, run_len = 0, last_run = 0, fall_cyc = 0, prev_fall = 0, fall_cnt = 0;
  int rsp_cnt = 0, err_cnt = 0;
  logic [7:0] last_rsp = 8'h00;
  logic [31:0] mosi_hist = '0;
  always @(negedge clk) begin
    cyc++;
    if (SS_n === 1'b0) begin
      if (run_len == 0) begin prev_fall = fall_cyc; fall_cyc = cyc; fall_cnt++; end
      run_len++;
      mosi_hist = {mosi_hist[30:0], MOSI};
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len = 0;
    end
    if (bus.rsp_valid === 1'b1) begin rsp_cnt++; last_rsp = bus.rsp_data; end
    if (bus.err === 1'b1) err_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    bus.req_valid = 1'b1; bus.req_cmd = c; bus.req_data = d;
    while (bus.req_ready !== 1'b1 && n < 200) begin step(); n++; end
    if (n >= 200) timeout("send_ready");
    step();
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.busy === 1'b0 && bus.req_ready === 1'b1) && n < 200) begin step(); n++; end
    if (n >= 200) timeout("wait_idle");
    repeat (3) step();
  endtask

  initial begin
    int r0, e0, f0, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    bus.req_valid = 1'b0; bus.req_cmd = 2'd0; bus.req_data = 8'h00;
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_ss_n", SS_n, 1); chk("rst_mosi", MOSI, 0); chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0); chk("rst_rsp_valid", bus.rsp_valid, 0); chk("rst_err", bus.err, 0);
    rst_n = 1'b1;
    step();
    send(2'd3, 8'h00, 0);
    repeat (3) step();
    chk("illegal_err_cnt", err_cnt, 1);
    chk("illegal_no_frame", fall_cnt, 0);
    chk("illegal_ready", bus.req_ready, 1);
    send(2'd0, 8'hA5, 0);
    wait_idle();
    chk("wr_ss_low", last_run, 11);
    chk("wr_mosi_bits", mosi_hist[10:0], 11'b00010100101);
    chk("wr_no_rsp", rsp_cnt, 0);
    send(2'd1, 8'h3C, 0);
    wait_idle();
    send(2'd2, 8'hA5, 0);
    wait_idle();
    r0 = rsp_cnt;
    send(2'd3, 8'h00, 0);
    wait_idle();
    chk("rd_ss_low", last_run, 11 + RD_LAT + 8);
    chk("rd_rsp_cnt", rsp_cnt, r0 + 1);
    chk("rd_rsp_data", last_rsp, 8'h3C);
    e0 = err_cnt;
    send(2'd3, 8'h00, 0);
    repeat (3) step();
    chk("rd_addr_cleared_err", err_cnt, e0 + 1);
    send(2'd1, 8'h5A, 1);
    send(2'd1, 8'hC3, 0);
    wait_idle();
    chk("b2b_gap", fall_cyc - prev_fall, 1 + 11 + GAP);
    send(2'd2, 8'h11, 0);
    wait_idle();
    r0 = rsp_cnt;
    send(2'd3, 8'h00, 0);
    n = 0;
    while (run_len != 11 + RD_LAT + 4 && n < 100) begin step(); n++; end
    if (n >= 100) timeout("recv_reach");
    rst_n = 1'b0;
    step();
    chk("midrst_ss_n", SS_n, 1);
    chk("midrst_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (30) step();
    chk("midrst_no_rsp", rsp_cnt, r0);
    e0 = err_cnt;
    f0 = fall_cnt;
    send(2'd3, 8'h00, 0);
    repeat (3) step();
    chk("midrst_err", err_cnt, e0 + 1);
    chk("midrst_no_frame", fall_cnt, f0);
    for (int i = 0; i < 4000; i++) begin
      bus.req_valid = ($urandom_range(0, 2) == 0);
      bus.req_cmd = 2'($urandom_range(0, 3));
      bus.req_data = 8'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
